approx_eval_sequencer: RTL
==========================

Name: approx_eval_sequencer

Overview:
Stimulus and error-accounting stage wrapped around a combinational approximate logic netlist (majority/AND graph, NUM_PI inputs, NUM_PO outputs).
- Upstream side: drives the netlist primary inputs with an exhaustive count or an LFSR sequence.
- Downstream side: compares the netlist outputs against a golden exact model and accumulates error-rate and bit-flip counts.
- Used on-chip and in simulation to characterise the error of each approximate candidate.

Parameters:
NUM_PI, 6, width of pi_out (primary inputs of the netlist under evaluation)
NUM_PO, 1, width of po_approx / po_exact
CNT_W, 16, width of vector and error counters
LAT, 1, cycles from a pi_out change to the cycle its po_* are sampled (1..4)
LFSR_TAPS, 6'b110000, Fibonacci feedback mask for LFSR mode (x^6+x^5+1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run (ignored while busy)
abort  in  1  one-cycle pulse; terminates the run
mode  in  1  0 = exhaustive, 1 = LFSR
seed  in  NUM_PI  LFSR start value
num_vectors  in  CNT_W  vectors to issue in LFSR mode
pi_out  out  NUM_PI  registered stimulus to the netlist
po_approx  in  NUM_PO  approximate netlist outputs
po_exact  in  NUM_PO  golden model outputs for the same vector
busy  out  1  high in RUN/DRAIN
done  out  1  high in DONE
vec_count  out  CNT_W  vectors compared so far
err_count  out  CNT_W  vectors with any mismatching bit
bit_err_count  out  CNT_W  total mismatching output bits

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: pi_out, busy, done, and all counters.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start at edge k:
  - clear all counters; drop done.
  - load pi_out = 0 (exhaustive) or seed (LFSR; seed 0 is replaced by 1).
  - latch total = 2^NUM_PI (exhaustive) or num_vectors (LFSR).
  - enter RUN. If total == 0, go directly to DONE with zero counts.
- RUN:
  - one vector per cycle; pi_out advances every edge (exhaustive: +1; LFSR: shift left, LSB = XOR of bits selected by LFSR_TAPS).
  - an issued counter tracks vectors issued; the last vector is held one cycle, then go to DRAIN.
  - pi_out holds its final value after the last vector.
- Valid pipeline:
  - LAT-deep shift register; a 1 enters for each issued vector.
  - when the tap at depth LAT is 1, sample the po_* pair:
    - vec_count +1
    - err_count +1 if (po_approx ^ po_exact) != 0
    - bit_err_count + popcount(po_approx ^ po_exact)
- DRAIN: wait until the valid pipeline is empty (LAT cycles), then go to DONE.
- Timing: done is first high at edge k + total + LAT.
- DONE: done = 1 and counters hold until the next start.
- Counters saturate at 2^CNT_W-1; no wrap.
- Exhaustive sweep uses an NUM_PI+1-bit internal index so 2^NUM_PI vectors are issued without wrap ambiguity.
- LFSR mode with num_vectors > period simply repeats the sequence.
- abort (any state): go to IDLE next edge; busy = 0, done stays 0, counters hold their partial values, the valid pipeline is flushed.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- Reset mid-run: immediate return to reset values; the partial run is lost.

Test Plan:
- Exhaustive, po_exact = po_approx every cycle, start at edge k -> pi_out walks 0..63; done at k+65 (LAT=1); vec_count = 64, err_count = 0, bit_err_count = 0.
- Exhaustive, golden model differs from approx only on input 6'h3F -> err_count = 1, bit_err_count = 1, vec_count = 64.
- NUM_PO=2, one vector with both bits inverted and one with a single bit inverted -> err_count = 2, bit_err_count = 3.
- LFSR, seed = 0, num_vectors = 63 -> first pi_out = 6'h01; all 63 nonzero values appear exactly once; vec_count = 63. num_vectors = 0 -> done next cycle, counts 0.
- CNT_W=4, all vectors mismatching, exhaustive -> err_count and bit_err_count saturate at 15.
- Abort at vector 20, then rst_n pulsed low mid-run on a second run -> after abort: busy = 0, done = 0, vec_count ≈ 20 held; after rst_n low: all outputs 0 asynchronously; the next start runs cleanly.

Source files
------------

// File: rtl/approx_eval_sequencer.sv
// approx_eval_sequencer
//   Drives the primary inputs of an approximate logic netlist with either an
//   exhaustive count or an LFSR sequence. It compares the netlist outputs
//   against a golden model and accumulates saturating error statistics.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    run control pulses (abort has priority; start ignored while busy)
//   mode            0 = exhaustive sweep, 1 = LFSR sequence
//   seed            LFSR start value (0 is replaced by 1)
//   num_vectors     vectors to issue in LFSR mode
//   pi_out          registered stimulus to the netlist
//   po_approx       approximate netlist outputs
//   po_exact        golden outputs for the same vector
//   busy, done      status (RUN/DRAIN, DONE)
//   vec_count       vectors compared
//   err_count       vectors with any mismatching bit
//   bit_err_count   total mismatching output bits
module approx_eval_sequencer #(
  parameter int                NUM_PI    = 6,
  parameter int                NUM_PO    = 1,
  parameter int                CNT_W     = 16,
  parameter int                LAT       = 1,
  parameter logic [NUM_PI-1:0] LFSR_TAPS = 6'b110000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [NUM_PI-1:0] seed,
  input  logic [CNT_W-1:0]  num_vectors,
  output logic [NUM_PI-1:0] pi_out,
  input  logic [NUM_PO-1:0] po_approx,
  input  logic [NUM_PO-1:0] po_exact,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  bit_err_count
);

  // Vector totals must hold both 2^NUM_PI and any num_vectors value.
  localparam int TOT_W = (CNT_W > NUM_PI + 1) ? CNT_W : NUM_PI + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_n;
  logic              mode_q;
  logic [TOT_W-1:0]  total, issued, tot_new;
  logic              start_ok, run_more, issue;
  // vld_pipe[i] = vector issued i edges ago is still in flight; tap LAT samples.
  logic [LAT:1]      vld_pipe;
  logic [NUM_PI-1:0] seed_eff, lfsr_next, pi_next;
  logic [NUM_PO-1:0] diff;
  logic [CNT_W:0]    pop, bit_sum;
  logic [CNT_W-1:0]  bit_sat;

  assign tot_new   = mode ? TOT_W'(num_vectors) : (TOT_W'(1) << NUM_PI);
  assign start_ok  = start && !abort && (state == S_IDLE || state == S_DONE);
  assign run_more  = (state == S_RUN) && (issued != total);
  assign issue     = !abort && ((start_ok && (tot_new != '0)) || run_more);

  assign seed_eff  = (seed == '0) ? NUM_PI'(1) : seed;
  assign lfsr_next = {pi_out[NUM_PI-2:0], ^(pi_out & LFSR_TAPS)};
  assign pi_next   = mode_q ? lfsr_next : pi_out + NUM_PI'(1);

  assign diff = po_approx ^ po_exact;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PO; i++) pop = pop + (CNT_W+1)'(diff[i]);
  end

  assign bit_sum = {1'b0, bit_err_count} + pop;
  assign bit_sat = bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = (state == S_RUN) || (state == S_DRAIN);
    done    = (state == S_DONE);
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (start) state_n = (tot_new == '0) ? S_DONE : S_RUN;
        // Last vector stays on pi_out one cycle before draining.
        S_RUN:          if (issued == total) state_n = S_DRAIN;
        S_DRAIN:        if (vld_pipe == '0) state_n = S_DONE;
        default:        state_n = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_out        <= '0;
      mode_q        <= 1'b0;
      total         <= '0;
      issued        <= '0;
      vld_pipe      <= '0;
      vec_count     <= '0;
      err_count     <= '0;
      bit_err_count <= '0;
    end else if (abort) begin
      // Partial counts stay visible; in-flight vectors are discarded.
      vld_pipe <= '0;
    end else begin
      vld_pipe <= LAT'({vld_pipe, issue});
      if (start_ok) begin
        pi_out        <= mode ? seed_eff : '0;
        mode_q        <= mode;
        total         <= tot_new;
        issued        <= (tot_new != '0) ? TOT_W'(1) : '0;
        vec_count     <= '0;
        err_count     <= '0;
        bit_err_count <= '0;
      end else begin
        if (run_more) begin
          pi_out <= pi_next;
          issued <= issued + TOT_W'(1);
        end
        if (vld_pipe[LAT]) begin
          if (vec_count != CNT_MAX) vec_count <= vec_count + CNT_W'(1);
          if ((diff != '0) && (err_count != CNT_MAX)) err_count <= err_count + CNT_W'(1);
          bit_err_count <= bit_sat;
        end
      end
    end
  end

endmodule
